// File: rtl/int_vector_ctrl_if.sv
// Interrupt controller bus: request lines, mask access and CPU handshake.
// master is the CPU/requester side, slave is the controller.
interface int_vector_ctrl_if #(
    parameter int unsigned NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_din;
    logic [NUM_IRQ-1:0] mask_q;
    logic               int_en;
    logic               intr;
    logic               inta;
    logic [7:0]         vector;
    logic               vector_valid;
    logic               eoi;
    logic [NUM_IRQ-1:0] in_service;

    modport master (
        output irq_in, mask_we, mask_din, int_en, inta, eoi,
        input  mask_q, intr, vector, vector_valid, in_service
    );

    modport slave (
        input  irq_in, mask_we, mask_din, int_en, inta, eoi,
        output mask_q, intr, vector, vector_valid, in_service
    );
endinterface

// File: rtl/int_vector_ctrl.sv
// Vectored interrupt controller: edge capture, masking, fixed priority with nesting,
// inta/vector handshake and eoi-driven in-service tracking.
module int_vector_ctrl #(
    parameter int unsigned NUM_IRQ   = 8,
    parameter logic [7:0]  VEC_BASE  = 8'h80,
    parameter int unsigned VEC_SHIFT = 2
) (
    input logic              clk,
    input logic              rst,
    int_vector_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StVec} state_e;

    localparam logic [NUM_IRQ-1:0] ONE      = NUM_IRQ'(1);
    localparam logic [7:0]         SPUR_VEC = VEC_BASE + (8'(NUM_IRQ) << VEC_SHIFT);

    state_e             state;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] in_service;
    logic [7:0]         vector;

    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] win_oh;
    logic [NUM_IRQ-1:0] ack_oh;
    logic [NUM_IRQ-1:0] eoi_oh;
    logic [3:0]         win_idx;
    logic [3:0]         svc_idx;
    logic               win_found;
    logic               svc_found;
    logic               eligible;
    logic               ack;
    logic [7:0]         win_vec;

    always_comb begin
        cand      = pending & ~mask;
        edges     = bus.irq_in & ~irq_prev;
        win_found = 1'b0;
        win_idx   = '0;
        svc_found = 1'b0;
        svc_idx   = '0;
        // Scan downward so the lowest set bit is the one left standing.
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = 4'(i);
            end
            if (in_service[i]) begin
                svc_found = 1'b1;
                svc_idx   = 4'(i);
            end
        end
        eligible = win_found && (!svc_found || (win_idx < svc_idx)) && bus.int_en;
        ack      = (state == StReq) && bus.inta && eligible;
        win_oh   = cand & ~(cand - ONE);
        ack_oh   = {NUM_IRQ{ack}} & win_oh;
        eoi_oh   = {NUM_IRQ{bus.eoi}} & in_service & ~(in_service - ONE);
        win_vec  = VEC_BASE + (8'(win_idx) << VEC_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            irq_prev   <= '0;
            pending    <= '0;
            mask       <= '1;
            in_service <= '0;
            vector     <= '0;
        end else begin
            irq_prev <= bus.irq_in;
            if (bus.mask_we) begin
                mask <= bus.mask_din;
            end
            // A fresh edge beats an ack of the same line.
            pending    <= (pending & ~ack_oh) | edges;
            // eoi retires the pre-ack top level, then the new level is added.
            in_service <= (in_service & ~eoi_oh) | ack_oh;
            unique case (state)
                StIdle: begin
                    if (eligible) begin
                        state <= StReq;
                    end
                end
                StReq: begin
                    if (bus.inta) begin
                        state  <= StVec;
                        vector <= ack ? win_vec : SPUR_VEC;
                    end else if (!eligible) begin
                        state <= StIdle;
                    end
                end
                StVec: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.intr         = (state == StReq);
    assign bus.vector_valid = (state == StVec);
    assign bus.vector       = vector;
    assign bus.mask_q       = mask;
    assign bus.in_service   = in_service;
endmodule

// File: tb/tb_int_vector_ctrl.sv
// Directed bench for int_vector_ctrl: expected vectors are queued at inta and
// compared when vector_valid appears.
module tb_int_vector_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    logic [7:0] exp_q[$];

    int_vector_ctrl_if #(.NUM_IRQ(8)) bus ();

    int_vector_ctrl #(
        .NUM_IRQ  (8),
        .VEC_BASE (8'h80),
        .VEC_SHIFT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_irq(input logic [7:0] lines);
        bus.irq_in = lines;
        tick();
        bus.irq_in = '0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we  = 1'b1;
        bus.mask_din = m;
        tick();
        bus.mask_we  = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic pop_cmp(input string tag);
        logic [7:0] e;
        chk({tag, " vv"}, 32'(bus.vector_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " vec"}, 32'(bus.vector), 32'(e));
        end
    endtask

    // Acknowledge an active request; vector_valid must last exactly one cycle.
    task automatic ack(input string tag, input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        pop_cmp(tag);
        tick();
        chk({tag, " vv drop"}, 32'(bus.vector_valid), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " intr"}, 32'(bus.intr), 32'd0);
        chk({tag, " vv"}, 32'(bus.vector_valid), 32'd0);
        chk({tag, " vector"}, 32'(bus.vector), 32'd0);
        chk({tag, " isr"}, 32'(bus.in_service), 32'd0);
        chk({tag, " mask"}, 32'(bus.mask_q), 32'hFF);
    endtask

    initial begin
        bus.irq_in   = '0;
        bus.mask_we  = 1'b0;
        bus.mask_din = '0;
        bus.int_en   = 1'b1;
        bus.inta     = 1'b0;
        bus.eoi      = 1'b0;
        #12;
        chk_reset("reset");
        rst = 1'b1;
        tick();

        // 1: single request on line 3
        write_mask(8'h00);
        chk("t1 mask", 32'(bus.mask_q), 32'h00);
        pulse_irq(8'h08);
        chk("t1 intr early", 32'(bus.intr), 32'd0);
        tick();
        chk("t1 intr", 32'(bus.intr), 32'd1);
        ack("t1", 8'h8C);
        chk("t1 isr", 32'(bus.in_service), 32'h08);
        pulse_eoi();
        chk("t1 eoi", 32'(bus.in_service), 32'h00);
        tick();
        tick();
        chk("t1 pending cleared", 32'(bus.intr), 32'd0);

        // 2: simultaneous edges on 5 and 2
        pulse_irq(8'h24);
        tick();
        chk("t2 intr", 32'(bus.intr), 32'd1);
        ack("t2a", 8'h88);
        chk("t2 isr a", 32'(bus.in_service), 32'h04);
        tick();
        tick();
        chk("t2 blocked", 32'(bus.intr), 32'd0);
        pulse_eoi();
        chk("t2 eoi a", 32'(bus.in_service), 32'h00);
        tick();
        chk("t2 intr b", 32'(bus.intr), 32'd1);
        ack("t2b", 8'h94);
        chk("t2 isr b", 32'(bus.in_service), 32'h20);
        pulse_eoi();
        chk("t2 eoi b", 32'(bus.in_service), 32'h00);

        // 3: nesting line 1 over line 4
        pulse_irq(8'h10);
        tick();
        ack("t3a", 8'h90);
        chk("t3 isr a", 32'(bus.in_service), 32'h10);
        pulse_irq(8'h02);
        tick();
        chk("t3 intr nest", 32'(bus.intr), 32'd1);
        ack("t3b", 8'h84);
        chk("t3 isr b", 32'(bus.in_service), 32'h12);
        pulse_eoi();
        chk("t3 eoi 1", 32'(bus.in_service), 32'h10);
        pulse_eoi();
        chk("t3 eoi 2", 32'(bus.in_service), 32'h00);

        // 4: masking and withdrawal
        write_mask(8'hFF);
        pulse_irq(8'h01);
        tick();
        tick();
        chk("t4 masked", 32'(bus.intr), 32'd0);
        write_mask(8'h00);
        tick();
        chk("t4 unmask", 32'(bus.intr), 32'd1);
        write_mask(8'hFF);
        tick();
        chk("t4 withdrawn", 32'(bus.intr), 32'd0);

        // 5: mask write alongside inta uses the old mask (line 0 still pending)
        write_mask(8'h00);
        tick();
        chk("t5 intr", 32'(bus.intr), 32'd1);
        exp_q.push_back(8'h80);
        bus.inta     = 1'b1;
        bus.mask_we  = 1'b1;
        bus.mask_din = 8'hFF;
        tick();
        bus.inta    = 1'b0;
        bus.mask_we = 1'b0;
        pop_cmp("t5 oldmask");
        tick();
        chk("t5 isr", 32'(bus.in_service), 32'h01);
        pulse_eoi();
        pulse_irq(8'h40);
        write_mask(8'h00);
        tick();
        chk("t5 intr 6", 32'(bus.intr), 32'd1);
        write_mask(8'hFF);
        tick();
        chk("t5 withdrawn", 32'(bus.intr), 32'd0);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        chk("t5 stray inta vv", 32'(bus.vector_valid), 32'd0);
        chk("t5 stray inta isr", 32'(bus.in_service), 32'h00);
        chk("t5 stray inta vec", 32'(bus.vector), 32'h80);
        write_mask(8'h00);
        tick();
        chk("t5 intr again", 32'(bus.intr), 32'd1);
        exp_q.push_back(8'hA0);
        bus.int_en = 1'b0;
        bus.inta   = 1'b1;
        tick();
        bus.inta = 1'b0;
        pop_cmp("t5 spurious");
        chk("t5 spur isr", 32'(bus.in_service), 32'h00);
        bus.int_en = 1'b1;
        tick();
        tick();
        chk("t5 intr kept", 32'(bus.intr), 32'd1);
        ack("t5 line6", 8'h98);
        chk("t5 isr 6", 32'(bus.in_service), 32'h40);
        pulse_eoi();

        // 6: asynchronous reset mid-REQ and mid-VEC
        pulse_irq(8'h04);
        tick();
        ack("t6a", 8'h88);
        pulse_irq(8'h02);
        tick();
        chk("t6 intr", 32'(bus.intr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("t6 req rst");
        #1;
        rst = 1'b1;
        tick();
        write_mask(8'h00);
        tick();
        tick();
        chk("t6 pending gone", 32'(bus.intr), 32'd0);
        pulse_irq(8'h08);
        tick();
        exp_q.push_back(8'h8C);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        pop_cmp("t6 vec");
        #2;
        rst = 1'b0;
        #1;
        chk_reset("t6 vec rst");
        #1;
        rst = 1'b1;
        tick();

        chk("queue empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
